rom_read_arbiter: RTL and testbench

- Shares the single-port sample ROM (18-bit address, 24-bit data, synchronous read) between up to NREQ read requesters, e.g. Main playback voices and the Display waveform viewer.
- Per requester: valid/ready request channel, plus a tagged response strobe on a shared data bus.
- Fully pipelined: one ROM read issued per cycle.
- Sits between the requesters and the ROM instance on the system clock.

---
 rtl/rom_read_arbiter.sv | 141 ++++++++++++++
 tb/tb_rom_read_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//   Shares one single-port synchronous sample ROM between NREQ read requesters.
//   One request is accepted per cycle (round-robin), its address is registered
//   onto the ROM address bus, and a {valid, one-hot id} tag travels alongside
//   the read so the ROM output can be steered back to its requester.
//   Handshake-to-response latency is 1+ROM_LAT cycles; responses are in order.
//
// Optional feature macro: ROM_ARB_PRIORITY_EN
//   When defined, requester 0 has absolute priority and round-robin applies to
//   requesters 1..NREQ-1 only (pointer range 1..NREQ-1, reset value 1).
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   [NREQ]          per-requester read pending
//   req_addr   in   [NREQ*ADDR_W]   requester i address at [i*ADDR_W +: ADDR_W]
//   req_ready  out  [NREQ]          one-hot grant, transfer on valid & ready
//   rsp_valid  out  [NREQ]          one-hot, marks rsp_data owner this cycle
//   rsp_data   out  [DATA_W]        shared response data (ROM douta pass-through)
//   rom_addr   out  [ADDR_W]        ROM addra
//   rom_data   in   [DATA_W]        ROM douta
//   busy       out  any read in flight
module rom_read_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 24,
  parameter int ROM_LAT = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     busy
);

  localparam int PTR_W = $clog2(NREQ);
`ifdef ROM_ARB_PRIORITY_EN
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(1);
`else
  localparam logic [PTR_W-1:0] PTR_RST = '0;
`endif

  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [PTR_W-1:0]  w_grant_idx;
  logic [PTR_W-1:0]  w_idx;
  logic              w_any;
  logic [NREQ-1:0]   w_grant_oh;

  logic [ADDR_W-1:0] r_rom_addr_p0;
  logic [ROM_LAT:0]  r_tag_vld_p;
  logic [NREQ-1:0]   r_tag_id_p [ROM_LAT+1];

  // Arbitration: first valid requester at or after the pointer, modulo the
  // round-robin set. Reset masks the grant so nothing is accepted meanwhile.
  always_comb begin
    w_any       = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    w_ptr_nxt   = r_ptr;
    w_grant_oh  = '0;
`ifdef ROM_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      // Requester 0 wins outright and leaves the rotation untouched.
      w_any = 1'b1;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        w_idx = PTR_W'(1 + ((int'(r_ptr) - 1 + k) % (NREQ - 1)));
        if (!w_any && req_valid[w_idx]) begin
          w_any       = 1'b1;
          w_grant_idx = w_idx;
          w_ptr_nxt   = (int'(w_idx) == NREQ - 1) ? PTR_W'(1) : PTR_W'(int'(w_idx) + 1);
        end
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % NREQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any       = 1'b1;
        w_grant_idx = w_idx;
        w_ptr_nxt   = PTR_W'((int'(w_idx) + 1) % NREQ);
      end
    end
`endif
    if (reset) begin
      w_any = 1'b0;
    end
    if (w_any) begin
      w_grant_oh[w_grant_idx] = 1'b1;
    end
  end

  assign req_ready = w_grant_oh;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= PTR_RST;
    end else if (w_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // ---- p0: issue stage, granted address registered onto the ROM bus ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rom_addr_p0 <= '0;
    end else if (w_any) begin
      r_rom_addr_p0 <= req_addr[w_grant_idx*ADDR_W +: ADDR_W];
    end
  end

  assign rom_addr = r_rom_addr_p0;

  // ---- p0..pROM_LAT: tag pipeline, in step with the ROM read latency ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag_vld_p <= '0;
    end else begin
      r_tag_vld_p <= {r_tag_vld_p[ROM_LAT-1:0], w_any};
    end
  end

  always_ff @(posedge clock) begin
    r_tag_id_p[0] <= w_grant_oh;
    for (int s = 1; s <= ROM_LAT; s++) begin
      r_tag_id_p[s] <= r_tag_id_p[s-1];
    end
  end

  // ---- response: last tag stage lines up with ROM douta ----
  assign rsp_valid = r_tag_id_p[ROM_LAT] & {NREQ{r_tag_vld_p[ROM_LAT]}};
  assign rsp_data  = rom_data;
  assign busy      = |r_tag_vld_p;

endmodule

// File: tb/tb_rom_read_arbiter.sv
module tb_rom_read_arbiter;

  localparam int NREQ    = 4;
  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 24;
  localparam int ROM_LAT = 2;

  logic                   clock;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic [ADDR_W-1:0]      rom_addr;
  logic [DATA_W-1:0]      rom_data;
  logic                   busy;

  int checks;
  int errors;

  rom_read_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM model: two-cycle synchronous read returning addr + 0x100000.
  logic [DATA_W-1:0] rom_d1, rom_d2;
  always @(posedge clock) begin
    rom_d1 <= 24'h100000 + {6'd0, rom_addr};
    rom_d2 <= rom_d1;
  end
  assign rom_data = rom_d2;

  // Start of a cycle: just after the rising edge. Checks happen on the falling edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    req_valid = '0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      reset = 1'b1;
      req_valid = 4'b1111;
      @(negedge clock);
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ready cycle %0d got %b want 0000", c, req_ready);
      end
    end
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (rom_addr !== 18'h00000) begin
      errors++;
      $display("FAIL reset_rom_addr got %h want 00000", rom_addr);
    end
    next_cycle();
    reset = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [NREQ-1:0]   exp_rsp;
    logic              exp_busy;
    // cycle 0: handshake
    next_cycle();
    req_valid = 4'b0010;
    req_addr[1*ADDR_W +: ADDR_W] = 18'h00010;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_ready got %b want 0010", req_ready);
    end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      req_valid = '0;
      @(negedge clock);
      exp_rsp  = (c == 3) ? 4'b0010 : 4'b0000;
      exp_busy = (c <= 3);
      checks++;
      if (rsp_valid !== exp_rsp) begin
        errors++;
        $display("FAIL single_rsp_valid cycle %0d got %b want %b", c, rsp_valid, exp_rsp);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL single_busy cycle %0d got %b want %b", c, busy, exp_busy);
      end
      checks++;
      if (rom_addr !== 18'h00010) begin
        errors++;
        $display("FAIL single_rom_addr cycle %0d got %h want 00010", c, rom_addr);
      end
      if (c == 3) begin
        checks++;
        if (rsp_data !== 24'h100010) begin
          errors++;
          $display("FAIL single_rsp_data got %h want 100010", rsp_data);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0]   exp_grant [8];
    logic [DATA_W-1:0] exp_data  [8];
    logic [DATA_W-1:0] data_of   [NREQ];
    logic [NREQ-1:0]   exp_ready;
    logic [NREQ-1:0]   exp_rsp;
    logic              exp_busy;
`ifdef ROM_ARB_PRIORITY_EN
    for (int i = 0; i < 8; i++) exp_grant[i] = 4'b0001;
`else
    exp_grant[0] = 4'b0001; exp_grant[1] = 4'b0010;
    exp_grant[2] = 4'b0100; exp_grant[3] = 4'b1000;
    exp_grant[4] = 4'b0001; exp_grant[5] = 4'b0010;
    exp_grant[6] = 4'b0100; exp_grant[7] = 4'b1000;
`endif
    data_of[0] = 24'h101000; data_of[1] = 24'h102000;
    data_of[2] = 24'h103000; data_of[3] = 24'h104000;
    for (int i = 0; i < 8; i++) begin
      exp_data[i] = 24'h0;
      for (int r = 0; r < NREQ; r++) if (exp_grant[i][r]) exp_data[i] = data_of[r];
    end
    do_reset();
    req_addr[0*ADDR_W +: ADDR_W] = 18'h01000;
    req_addr[1*ADDR_W +: ADDR_W] = 18'h02000;
    req_addr[2*ADDR_W +: ADDR_W] = 18'h03000;
    req_addr[3*ADDR_W +: ADDR_W] = 18'h04000;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      @(negedge clock);
      exp_ready = (c < 8) ? exp_grant[c] : 4'b0000;
      exp_rsp   = (c >= 3 && c < 11) ? exp_grant[c-3] : 4'b0000;
      exp_busy  = (c >= 1 && c <= 10);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL rr_ready cycle %0d got %b want %b", c, req_ready, exp_ready);
      end
      checks++;
      if (rsp_valid !== exp_rsp) begin
        errors++;
        $display("FAIL rr_rsp_valid cycle %0d got %b want %b", c, rsp_valid, exp_rsp);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL rr_busy cycle %0d got %b want %b", c, busy, exp_busy);
      end
      if (c >= 3 && c < 11) begin
        checks++;
        if (rsp_data !== exp_data[c-3]) begin
          errors++;
          $display("FAIL rr_rsp_data cycle %0d got %h want %h", c, rsp_data, exp_data[c-3]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] datas [3];
    logic [NREQ-1:0]   exp_rsp;
    addrs[0] = 18'h3FFFE; addrs[1] = 18'h3FFFF; addrs[2] = 18'h00000;
    datas[0] = 24'h13FFFE; datas[1] = 24'h13FFFF; datas[2] = 24'h100000;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if (c < 3) begin
        req_valid = 4'b0100;
        req_addr[2*ADDR_W +: ADDR_W] = addrs[c];
      end else begin
        req_valid = 4'b0000;
      end
      @(negedge clock);
      if (c < 3) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          errors++;
          $display("FAIL b2b_ready cycle %0d got %b want 0100", c, req_ready);
        end
      end
      exp_rsp = (c >= 3 && c < 6) ? 4'b0100 : 4'b0000;
      checks++;
      if (rsp_valid !== exp_rsp) begin
        errors++;
        $display("FAIL b2b_rsp_valid cycle %0d got %b want %b", c, rsp_valid, exp_rsp);
      end
      if (c >= 3 && c < 6) begin
        checks++;
        if (rsp_data !== datas[c-3]) begin
          errors++;
          $display("FAIL b2b_rsp_data cycle %0d got %h want %h", c, rsp_data, datas[c-3]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // cycle 0: grant to requester 3
    next_cycle();
    req_valid = 4'b1000;
    req_addr[3*ADDR_W +: ADDR_W] = 18'h2AAAA;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rmid_grant got %b want 1000", req_ready);
    end
    // cycle 1: reset, requester still asserting valid
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_ready_in_reset got %b want 0000", req_ready);
    end
    next_cycle();
    reset = 1'b0;
    req_valid = 4'b0000;
    @(negedge clock);
    checks++;
    if (rom_addr !== 18'h00000) begin
      errors++;
      $display("FAIL rmid_rom_addr got %h want 00000", rom_addr);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_busy got %b want 0", busy);
    end
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      @(negedge clock);
      checks++;
      if (rsp_valid !== 4'b0000) begin
        errors++;
        $display("FAIL rmid_rsp_valid cycle %0d got %b want 0000", c, rsp_valid);
      end
    end
    // ptr back at its reset value: contention between 0 and 3 goes to 0
    next_cycle();
    req_valid = 4'b1001;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_ptr_after got %b want 0001", req_ready);
    end
    next_cycle();
    req_valid = 4'b0000;
  endtask

  task automatic test_priority();
    logic [NREQ-1:0] exp_seq [4];
`ifdef ROM_ARB_PRIORITY_EN
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0001;
    exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0100;
`else
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0100;
    exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0100;
`endif
    do_reset();
    req_addr[0*ADDR_W +: ADDR_W] = 18'h00100;
    req_addr[2*ADDR_W +: ADDR_W] = 18'h00300;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      req_valid = (c < 3) ? 4'b0101 : 4'b0100;
      @(negedge clock);
      checks++;
      if (req_ready !== exp_seq[c]) begin
        errors++;
        $display("FAIL prio_ready cycle %0d got %b want %b", c, req_ready, exp_seq[c]);
      end
    end
    next_cycle();
    req_valid = 4'b0000;
    for (int c = 0; c < 4; c++) next_cycle();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
